seg_scan_decoder: RTL

Reads a multiplexed, active-low 7-segment digit bus (segments a..g plus per-digit anode selects) and reconstructs the BCD value of every digit. This is the receive side of our BCD-to-7-segment display path. It is used for display loopback checking and for capturing readings from external multiplexed displays. Inputs are synchronised and must hold stable before a capture, then each pattern is decoded back to BCD with blank/invalid detection.

---
 rtl/seg_scan_decoder.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/seg_scan_decoder.sv
// -----------------------------------------------------------------------------
// seg_scan_decoder
//
// Receive side of the BCD-to-7-segment display path. Watches a multiplexed,
// active-low 7-segment bus and rebuilds the BCD value of every digit. It is
// used for display loopback checking and for capturing external displays.
// Segment and anode inputs are synchronised. The combined sample must hold
// for STABLE_CYCLES consecutive clocks before the selected digit is captured.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   seg[0:6]     segments a..g, active-low (0 = lit)
//   an           digit selects, active-low, one bit per digit
//   clr          synchronous clear of all captured results
//   bcd_out      digit i at [4i+3:4i]; 4'hF for a blank digit
//   digit_valid  digit i captured since reset/clr
//   blank        digit i last captured as all segments off
//   err          sticky, set when an undecodable pattern is captured
//   frame_done   one-cycle pulse when the last digit completes a full frame
//   err_count    (ERR_COUNT_EN only) saturating count of invalid captures
//
// Build option: define ERR_COUNT_EN to add the err_count[7:0] output.
// -----------------------------------------------------------------------------
module seg_scan_decoder #(
   parameter int NUM_DIGITS    = 4,
   parameter int STABLE_CYCLES = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [0:6]              seg,
   input  logic [NUM_DIGITS-1:0]   an,
   input  logic                    clr,
   output logic [4*NUM_DIGITS-1:0] bcd_out,
   output logic [NUM_DIGITS-1:0]   digit_valid,
   output logic [NUM_DIGITS-1:0]   blank,
   output logic                    err,
   output logic                    frame_done
`ifdef ERR_COUNT_EN
   ,
   output logic [7:0]              err_count
`endif
);

   // state    | meaning
   // ST_IDLE  | no single digit selected, waiting for exactly one active anode
   // ST_TRACK | counting consecutive identical samples of one selected digit
   // ST_HOLD  | digit captured, waiting for the sample to change
   typedef enum logic [1:0] {
      ST_IDLE,
      ST_TRACK,
      ST_HOLD
   } state_t;

   localparam int         SW        = NUM_DIGITS + 7;
   localparam logic [7:0] STABLE_LP = 8'(STABLE_CYCLES);

   logic [0:6]            r_seg_m, r_seg_s;
   logic [NUM_DIGITS-1:0] r_an_m, r_an_s;

   state_t                r_state, w_state_nxt;
   logic [7:0]            r_cnt, w_cnt_nxt;
   logic [SW-1:0]         r_ref, w_ref_nxt;

   logic [SW-1:0]         w_samp;
   logic [NUM_DIGITS-1:0] w_sel;
   logic                  w_onehot;
   logic                  w_same;
   logic                  w_capture;
   logic [4:0]            w_dec;
   logic                  w_is_blank;

   logic [4*NUM_DIGITS-1:0] r_bcd;
   logic [NUM_DIGITS-1:0]   r_valid;
   logic [NUM_DIGITS-1:0]   r_blank;
   logic                    r_err;
   logic                    r_frame_done;
`ifdef ERR_COUNT_EN
   logic [7:0]              r_err_count;
`endif

   // {ok, value}; ok is low for anything that is not a digit 0..9
   function automatic logic [4:0] f_decode(input logic [0:6] s);
      case (s)
         7'b0000001: f_decode = {1'b1, 4'd0};
         7'b1001111: f_decode = {1'b1, 4'd1};
         7'b0010010: f_decode = {1'b1, 4'd2};
         7'b0000110: f_decode = {1'b1, 4'd3};
         7'b1001100: f_decode = {1'b1, 4'd4};
         7'b0100100: f_decode = {1'b1, 4'd5};
         7'b1100000: f_decode = {1'b1, 4'd6};
         7'b0001111: f_decode = {1'b1, 4'd7};
         7'b0000000: f_decode = {1'b1, 4'd8};
         7'b0001100: f_decode = {1'b1, 4'd9};
         default:    f_decode = 5'b0_0000;
      endcase
   endfunction

   // Synchronisers idle at all-ones so nothing looks selected or lit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_seg_m <= '1;
         r_seg_s <= '1;
         r_an_m  <= '1;
         r_an_s  <= '1;
      end else begin
         r_seg_m <= seg;
         r_seg_s <= r_seg_m;
         r_an_m  <= an;
         r_an_s  <= r_an_m;
      end
   end

   assign w_samp     = {r_an_s, r_seg_s};
   assign w_sel      = ~r_an_s;
   assign w_onehot   = (w_sel != '0) && ((w_sel & (w_sel - NUM_DIGITS'(1))) == '0);
   assign w_same     = (w_samp == r_ref);
   assign w_dec      = f_decode(r_seg_s);
   assign w_is_blank = (r_seg_s == 7'b1111111);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_cnt   <= 8'd0;
         r_ref   <= '1;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_ref   <= w_ref_nxt;
      end
   end

   // Any change of the combined sample restarts tracking (or drops to idle),
   // so a simultaneous anode and segment change counts as a single change.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_ref_nxt   = r_ref;
      w_capture   = 1'b0;
      if ((r_state == ST_IDLE) || !w_same) begin
         w_ref_nxt = w_samp;
         if (w_onehot) begin
            w_state_nxt = ST_TRACK;
            w_cnt_nxt   = 8'd1;
         end else begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = 8'd0;
         end
      end else if (r_state == ST_TRACK) begin
         w_cnt_nxt = r_cnt + 8'd1;
         if ((r_cnt + 8'd1) == STABLE_LP) begin
            w_capture   = 1'b1;
            w_state_nxt = ST_HOLD;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_bcd        <= '0;
         r_valid      <= '0;
         r_blank      <= '0;
         r_err        <= 1'b0;
         r_frame_done <= 1'b0;
`ifdef ERR_COUNT_EN
         r_err_count  <= 8'd0;
`endif
      end else if (clr) begin
         r_bcd        <= '0;
         r_valid      <= '0;
         r_blank      <= '0;
         r_err        <= 1'b0;
         r_frame_done <= 1'b0;
`ifdef ERR_COUNT_EN
         r_err_count  <= 8'd0;
`endif
      end else begin
         r_frame_done <= 1'b0;
         if (w_capture) begin
            if (w_dec[4] || w_is_blank) begin
               for (int i = 0; i < NUM_DIGITS; i++) begin
                  if (w_sel[i]) begin
                     r_bcd[4*i +: 4] <= w_is_blank ? 4'hF : w_dec[3:0];
                     r_valid[i]      <= 1'b1;
                     r_blank[i]      <= w_is_blank;
                  end
               end
               r_frame_done <= w_sel[NUM_DIGITS-1] && ((r_valid | w_sel) == '1);
            end else begin
               r_err <= 1'b1;
`ifdef ERR_COUNT_EN
               if (r_err_count != 8'hFF) begin
                  r_err_count <= r_err_count + 8'd1;
               end
`endif
            end
         end
      end
   end

   assign bcd_out     = r_bcd;
   assign digit_valid = r_valid;
   assign blank       = r_blank;
   assign err         = r_err;
   assign frame_done  = r_frame_done;
`ifdef ERR_COUNT_EN
   assign err_count   = r_err_count;
`endif

endmodule
